execute_pipe: RTL and testbench
===============================

# execute_pipe

Parametrised execute stage with EX/MEM pipeline register: N-source operand forwarding, full ALU with branch resolution, and an optional iterative multi-cycle multiplier that stalls upstream through a busy handshake. Sits between decode/ID-EX and the memory stage. Generalises the fixed 32-bit, single-forward-source stage to configurable width, forwarding fan-in and multi-cycle operations.

## Interface
- XLEN, 32, datapath width (power of two, ≥8)
- REG_AW, 5, register-index width
- FWD_SRCS, 2, number of forwarding sources; FSEL_W = $clog2(FWD_SRCS+1)
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i, stall_i  in  1  kill current EX/MEM capture; hold EX/MEM (downstream stall)
- valid_i  in  1  instruction present in EX
- read_data1_i, read_data2_i, imm_i, pc_i  in  XLEN  operands, immediate, PC
- fwd_data_i  in  FWD_SRCS*XLEN  forwarding values, source k at [k*XLEN +: XLEN]
- fwd_sel1_i, fwd_sel2_i  in  FSEL_W  0 = register file, k = source k-1, >FWD_SRCS = register file
- alu_op_i  in  4  ALU op; imm_sel_i  in  1  B operand = imm_i
- mul_i, mul_high_i  in  1  multi-cycle unsigned multiply; return high half
- branch_type_i  in  2  0 none, 1 conditional, 2 jal, 3 jalr
- wb_sel_i, reg_write_enable_i, mem_write_enable_i  in  1  passed to EX/MEM
- write_reg_sel_i  in  REG_AW  destination register
- result_o, pc_o, read_data2_o  out  XLEN  EX/MEM result, next PC, forwarded rs2 (store data)
- valid_o, wb_sel_o, reg_write_enable_o, mem_write_enable_o  out  1  EX/MEM control
- write_reg_sel_o  out  REG_AW  EX/MEM destination
- busy_o  out  1  EX occupied; upstream must hold all inputs
- e_dest_reg_o  out  REG_AW  = write_reg_sel_i (hazard unit)
- e_dest_reg_en_o  out  1  = reg_write_enable_i & valid_i
- e_valid_o  out  1  = !busy_o

## Operation
- A = forwarded rs1, B2 = forwarded rs2, B = imm_sel_i ? imm_i : B2. read_data2_o captures B2.
- alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shamt = B[$clog2(XLEN)-1:0]), 8 SLT, 9 SLTU (result 0/1), 10 EQ, 11 NE, 12 LT signed, 13 GEU; 10-13 set branch flag, result = flag; 14-15 result 0, flag 0. Arithmetic wraps modulo 2^XLEN.
- Next PC: type 0 → pc_i+4; 1 → flag ? pc_i+imm_i : pc_i+4; 2 → pc_i+imm_i; 3 → (A+imm_i) & ~1.
- Multiplier FSM IDLE/MUL/DONE, shift-add one bit per cycle, 2*XLEN-bit accumulator, $clog2(XLEN)+1-bit counter.
  - IDLE: valid_i & mul_i & !flush_i → MUL, latch A, B, mul_high_i, clear accumulator and counter.
  - MUL: XLEN iterations, then → DONE. Continues regardless of stall_i.
  - DONE: !stall_i → capture product half into result_o, → IDLE; stall_i → remain.
  - flush_i in MUL or DONE → IDLE, no capture.
- busy_o = (IDLE & valid_i & mul_i & !flush_i) | MUL | (DONE & stall_i).
- EX/MEM register priority: flush_i > stall_i > busy_o > load. Flush: valid_o, reg/mem write enables ← 0, pc_o ← pc_i, others load. Stall: hold all. Busy (non-DONE): valid_o, write enables ← 0, data hold. Load: all from EX, valid_o ← valid_i; write enables gated by valid_i.

## Timing
- Reset: every output register 0, FSM IDLE; busy_o 0 unless valid_i & mul_i.
- ALU ops: 1-cycle latency; inputs at edge T, EX/MEM outputs valid after edge T+1.
- Multiply presented at T: busy_o high T..T+XLEN, DONE during T+XLEN+1 (busy_o low if !stall_i), valid_o/result_o after edge T+XLEN+2. Inputs held constant by upstream throughout.
- Flush and stall same cycle: flush wins. Reset mid-multiply: immediate IDLE, accumulator discarded.
- Back-to-back multiplies: second enters MUL the cycle after DONE captures.

## Configuration
- EXE_MUL_EN defined: multiplier FSM and busy logic compiled in as above.
- Undefined: FSM removed, mul_i/mul_high_i ignored (instruction executes as plain ALU op), busy_o tied 0, e_valid_o tied 1.

## Test plan
- XLEN=32, ADD A=0xFFFFFFFF B=2, imm_sel_i=0 → result_o=0x00000001, valid_o=1 one cycle later.
- fwd_sel1_i=2, source 1=0x1234, read_data1_i=0, imm_i=4, imm_sel_i=1, ADD → result_o=0x1238; fwd_sel1_i=3 → uses read_data1_i.
- Branch type 1, op NE, A=5 B=6, pc_i=0x100, imm_i=0x20 → pc_o=0x120; A=B → pc_o=0x104; jalr A=0x201 imm 0 → pc_o=0x200.
- EXE_MUL_EN, mul A=0xFFFFFFFF B=0xFFFFFFFF, mul_high_i=1 → busy_o high 33 cycles, result_o=0xFFFFFFFE, valid_o 1 at T+34; mul_high_i=0 → 0x00000001.
- Multiply with stall_i held from T+20 to T+40 → FSM waits in DONE, result captured edge after stall_i falls, no duplicate valid_o.
- flush_i at T+10 of multiply → busy_o low next cycle, valid_o=0, reg_write_enable_o=0, pc_o=pc_i.

Source files
------------

// File: rtl/execute_pipe.sv
// execute_pipe
// Execute stage plus EX/MEM pipeline register for the integer pipeline.
// Sits between the ID/EX register and the memory stage.
//
// Optional feature macro: EXE_MUL_EN
//   defined   - iterative shift-add unsigned multiplier (one bit per cycle)
//               that holds upstream through busy_o while it works.
//   undefined - no multiplier; mul_i/mul_high_i are ignored, busy_o is 0
//               and e_valid_o is 1.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   flush_i                   kill the EX/MEM capture this cycle
//   stall_i                   downstream stall, EX/MEM holds
//   valid_i                   an instruction is present in EX
//   read_data1_i/2_i          register-file operands
//   imm_i, pc_i               immediate and PC of the instruction
//   fwd_data_i                forwarding values, source k at [k*XLEN +: XLEN]
//   fwd_sel1_i/2_i            0 = register file, k = source k-1, larger = register file
//   alu_op_i, imm_sel_i       ALU operation, B operand from immediate
//   mul_i, mul_high_i         multi-cycle multiply, return high half
//   branch_type_i             0 none, 1 conditional, 2 jal, 3 jalr
//   wb_sel_i, reg_write_enable_i, mem_write_enable_i, write_reg_sel_i
//                             control passed through to EX/MEM
//   result_o, pc_o, read_data2_o, valid_o, wb_sel_o, reg_write_enable_o,
//   mem_write_enable_o, write_reg_sel_o
//                             EX/MEM register contents
//   busy_o                    EX occupied, upstream must hold its inputs
//   e_dest_reg_o, e_dest_reg_en_o, e_valid_o
//                             EX-stage information for the hazard unit
module execute_pipe #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int FWD_SRCS = 2,
  localparam int FSEL_W  = $clog2(FWD_SRCS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     stall_i,
  input  logic                     valid_i,
  input  logic [XLEN-1:0]          read_data1_i,
  input  logic [XLEN-1:0]          read_data2_i,
  input  logic [XLEN-1:0]          imm_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [FWD_SRCS*XLEN-1:0] fwd_data_i,
  input  logic [FSEL_W-1:0]        fwd_sel1_i,
  input  logic [FSEL_W-1:0]        fwd_sel2_i,
  input  logic [3:0]               alu_op_i,
  input  logic                     imm_sel_i,
  input  logic                     mul_i,
  input  logic                     mul_high_i,
  input  logic [1:0]               branch_type_i,
  input  logic                     wb_sel_i,
  input  logic                     reg_write_enable_i,
  input  logic                     mem_write_enable_i,
  input  logic [REG_AW-1:0]        write_reg_sel_i,
  output logic [XLEN-1:0]          result_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          read_data2_o,
  output logic                     valid_o,
  output logic                     wb_sel_o,
  output logic                     reg_write_enable_o,
  output logic                     mem_write_enable_o,
  output logic [REG_AW-1:0]        write_reg_sel_o,
  output logic                     busy_o,
  output logic [REG_AW-1:0]        e_dest_reg_o,
  output logic                     e_dest_reg_en_o,
  output logic                     e_valid_o
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b2;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ex_result;
  logic [SHW-1:0]  shamt;
  logic            branch_flag;
  logic            busy;

  // Selector values beyond the number of sources fall back to the register file.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [FSEL_W-1:0]        sel,
    input logic [XLEN-1:0]          rf_val,
    input logic [FWD_SRCS*XLEN-1:0] fwd
  );
    logic [XLEN-1:0] val;
    val = rf_val;
    for (int k = 1; k <= FWD_SRCS; k++) begin
      if (sel == FSEL_W'(k)) val = fwd[(k-1)*XLEN +: XLEN];
    end
    return val;
  endfunction

  always_comb begin
    op_a  = fwd_pick(fwd_sel1_i, read_data1_i, fwd_data_i);
    op_b2 = fwd_pick(fwd_sel2_i, read_data2_i, fwd_data_i);
    op_b  = imm_sel_i ? imm_i : op_b2;
    shamt = op_b[SHW-1:0];
  end

  // Comparison ops double as branch conditions; their result is the flag itself.
  always_comb begin
    branch_flag = 1'b0;
    case (alu_op_i)
      4'd10:   branch_flag = (op_a == op_b);
      4'd11:   branch_flag = (op_a != op_b);
      4'd12:   branch_flag = ($signed(op_a) < $signed(op_b));
      4'd13:   branch_flag = (op_a >= op_b);
      default: branch_flag = 1'b0;
    endcase

    alu_result = '0;
    case (alu_op_i)
      4'd0:    alu_result = op_a + op_b;
      4'd1:    alu_result = op_a - op_b;
      4'd2:    alu_result = op_a & op_b;
      4'd3:    alu_result = op_a | op_b;
      4'd4:    alu_result = op_a ^ op_b;
      4'd5:    alu_result = op_a << shamt;
      4'd6:    alu_result = op_a >> shamt;
      4'd7:    alu_result = $signed(op_a) >>> shamt;
      4'd8:    alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9:    alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd10, 4'd11, 4'd12, 4'd13:
               alu_result = {{(XLEN-1){1'b0}}, branch_flag};
      default: alu_result = '0;
    endcase
  end

  // jalr clears bit 0 of the target.
  always_comb begin
    next_pc = pc_i + XLEN'(4);
    case (branch_type_i)
      2'd1:    next_pc = branch_flag ? (pc_i + imm_i) : (pc_i + XLEN'(4));
      2'd2:    next_pc = pc_i + imm_i;
      2'd3:    next_pc = (op_a + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
      default: next_pc = pc_i + XLEN'(4);
    endcase
  end

`ifdef EXE_MUL_EN
  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

  localparam int CNT_W = $clog2(XLEN) + 1;

  mul_state_e        state_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              high_q;
  logic              mul_start;
  logic [XLEN:0]     partial_sum;
  logic [XLEN-1:0]   product_sel;

  assign mul_start = valid_i & mul_i & ~flush_i;

  // Right-shifting accumulator: add the multiplicand into the upper half when
  // the current multiplier bit is set, then shift the whole thing right by one.
  // After XLEN steps acc_q holds the full 2*XLEN-bit product.
  assign partial_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                     + {1'b0, (mplier_q[0] ? mcand_q : {XLEN{1'b0}})};

  // The multiply keeps running under stall_i; only DONE waits for the stall to
  // clear before handing its product to EX/MEM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      high_q   <= 1'b0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (mul_start) begin
            state_q  <= MUL_RUN;
            mcand_q  <= op_a;
            mplier_q <= op_b;
            high_q   <= mul_high_i;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        MUL_RUN: begin
          if (flush_i) begin
            state_q <= MUL_IDLE;
          end else begin
            acc_q    <= {partial_sum, acc_q[XLEN-1:1]};
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) state_q <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          if (flush_i || !stall_i) state_q <= MUL_IDLE;
        end
        default: state_q <= MUL_IDLE;
      endcase
    end
  end

  assign busy = ((state_q == MUL_IDLE) & mul_start)
              | (state_q == MUL_RUN)
              | ((state_q == MUL_DONE) & stall_i);

  assign product_sel = high_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign ex_result   = (state_q == MUL_DONE) ? product_sel : alu_result;
`else
  logic unused_mul_ctrl;

  assign unused_mul_ctrl = mul_i ^ mul_high_i;
  assign busy            = 1'b0;
  assign ex_result       = alu_result;
`endif

  assign busy_o          = busy;
  assign e_valid_o       = ~busy;
  assign e_dest_reg_o    = write_reg_sel_i;
  assign e_dest_reg_en_o = reg_write_enable_i & valid_i;

  // Priority: flush, then stall, then busy, then a normal load.
  // A flushed slot still records pc_i so the redirect target is visible.
  // While the multiplier is busy a bubble is emitted but the data is held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_o           <= '0;
      pc_o               <= '0;
      read_data2_o       <= '0;
      valid_o            <= 1'b0;
      wb_sel_o           <= 1'b0;
      reg_write_enable_o <= 1'b0;
      mem_write_enable_o <= 1'b0;
      write_reg_sel_o    <= '0;
    end else if (flush_i) begin
      result_o           <= ex_result;
      pc_o               <= pc_i;
      read_data2_o       <= op_b2;
      valid_o            <= 1'b0;
      wb_sel_o           <= wb_sel_i;
      reg_write_enable_o <= 1'b0;
      mem_write_enable_o <= 1'b0;
      write_reg_sel_o    <= write_reg_sel_i;
    end else if (stall_i) begin
      result_o           <= result_o;
    end else if (busy) begin
      valid_o            <= 1'b0;
      reg_write_enable_o <= 1'b0;
      mem_write_enable_o <= 1'b0;
    end else begin
      result_o           <= ex_result;
      pc_o               <= next_pc;
      read_data2_o       <= op_b2;
      valid_o            <= valid_i;
      wb_sel_o           <= wb_sel_i;
      reg_write_enable_o <= reg_write_enable_i & valid_i;
      mem_write_enable_o <= mem_write_enable_i & valid_i;
      write_reg_sel_o    <= write_reg_sel_i;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe
// Scoreboard bench for execute_pipe (XLEN=32, two forwarding sources).
// Expected EX/MEM contents are computed from the driven inputs by a small
// reference model and queued; they are popped and compared when the DUT
// produces its output. Multiply tests are compiled when EXE_MUL_EN is set.
module tb_execute_pipe;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int FWD_SRCS = 2;
  localparam int FSEL_W   = $clog2(FWD_SRCS + 1);

  logic                     clk_i;
  logic                     rst_n_i;
  logic                     flush_i;
  logic                     stall_i;
  logic                     valid_i;
  logic [XLEN-1:0]          read_data1_i;
  logic [XLEN-1:0]          read_data2_i;
  logic [XLEN-1:0]          imm_i;
  logic [XLEN-1:0]          pc_i;
  logic [FWD_SRCS*XLEN-1:0] fwd_data_i;
  logic [FSEL_W-1:0]        fwd_sel1_i;
  logic [FSEL_W-1:0]        fwd_sel2_i;
  logic [3:0]               alu_op_i;
  logic                     imm_sel_i;
  logic                     mul_i;
  logic                     mul_high_i;
  logic [1:0]               branch_type_i;
  logic                     wb_sel_i;
  logic                     reg_write_enable_i;
  logic                     mem_write_enable_i;
  logic [REG_AW-1:0]        write_reg_sel_i;
  logic [XLEN-1:0]          result_o;
  logic [XLEN-1:0]          pc_o;
  logic [XLEN-1:0]          read_data2_o;
  logic                     valid_o;
  logic                     wb_sel_o;
  logic                     reg_write_enable_o;
  logic                     mem_write_enable_o;
  logic [REG_AW-1:0]        write_reg_sel_o;
  logic                     busy_o;
  logic [REG_AW-1:0]        e_dest_reg_o;
  logic                     e_dest_reg_en_o;
  logic                     e_valid_o;

  execute_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_SRCS(FWD_SRCS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .stall_i(stall_i),
    .valid_i(valid_i), .read_data1_i(read_data1_i), .read_data2_i(read_data2_i),
    .imm_i(imm_i), .pc_i(pc_i), .fwd_data_i(fwd_data_i),
    .fwd_sel1_i(fwd_sel1_i), .fwd_sel2_i(fwd_sel2_i), .alu_op_i(alu_op_i),
    .imm_sel_i(imm_sel_i), .mul_i(mul_i), .mul_high_i(mul_high_i),
    .branch_type_i(branch_type_i), .wb_sel_i(wb_sel_i),
    .reg_write_enable_i(reg_write_enable_i), .mem_write_enable_i(mem_write_enable_i),
    .write_reg_sel_i(write_reg_sel_i), .result_o(result_o), .pc_o(pc_o),
    .read_data2_o(read_data2_o), .valid_o(valid_o), .wb_sel_o(wb_sel_o),
    .reg_write_enable_o(reg_write_enable_o), .mem_write_enable_o(mem_write_enable_o),
    .write_reg_sel_o(write_reg_sel_o), .busy_o(busy_o), .e_dest_reg_o(e_dest_reg_o),
    .e_dest_reg_en_o(e_dest_reg_en_o), .e_valid_o(e_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string             tag;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd2;
    logic              valid;
    logic              wb;
    logic              rwe;
    logic              mwe;
    logic [REG_AW-1:0] wrs;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  int   errors = 0;
  int   checks = 0;

  vec_t vecs [0:16] = '{
    '{4'd0,  32'd7,        32'd8,        32'd15},
    '{4'd1,  32'd0,        32'd1,        32'hFFFFFFFF},
    '{4'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000},
    '{4'd3,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF},
    '{4'd4,  32'h0000FFFF, 32'h00000F0F, 32'h0000F0F0},
    '{4'd5,  32'd1,        32'd31,       32'h80000000},
    '{4'd5,  32'd1,        32'h21,       32'd2},
    '{4'd6,  32'h80000000, 32'd4,        32'h08000000},
    '{4'd7,  32'h80000000, 32'd4,        32'hF8000000},
    '{4'd8,  32'hFFFFFFFF, 32'd1,        32'd1},
    '{4'd9,  32'hFFFFFFFF, 32'd1,        32'd0},
    '{4'd10, 32'd5,        32'd5,        32'd1},
    '{4'd11, 32'd5,        32'd5,        32'd0},
    '{4'd12, 32'd1,        32'hFFFFFFFF, 32'd0},
    '{4'd13, 32'hFFFFFFFF, 32'd1,        32'd1},
    '{4'd14, 32'd3,        32'd4,        32'd0},
    '{4'd15, 32'd3,        32'd4,        32'd0}
  };

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelFwd(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'd1:    return fwd_data_i[31:0];
      2'd2:    return fwd_data_i[63:32];
      default: return rf;
    endcase
  endfunction

  function automatic logic modelFlag(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd10:   return a == b;
      4'd11:   return a != b;
      4'd12:   return $signed(a) < $signed(b);
      4'd13:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] modelAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[4:0];
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $signed(a) >>> b[4:0];
      4'd8:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    r = (a < b) ? 32'd1 : 32'd0;
      4'd10, 4'd11, 4'd12, 4'd13:
               r = modelFlag(op, a, b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Expected EX/MEM contents for a normal load of the currently driven inputs.
  function automatic exp_t modelLoad(input string tag);
    exp_t        e;
    logic [31:0] a, b2, b;
    logic        flag;
    a    = modelFwd(fwd_sel1_i, read_data1_i);
    b2   = modelFwd(fwd_sel2_i, read_data2_i);
    b    = imm_sel_i ? imm_i : b2;
    flag = modelFlag(alu_op_i, a, b);
    e.tag    = tag;
    e.result = modelAlu(alu_op_i, a, b);
    case (branch_type_i)
      2'd0:    e.pc = pc_i + 32'd4;
      2'd1:    e.pc = flag ? pc_i + imm_i : pc_i + 32'd4;
      2'd2:    e.pc = pc_i + imm_i;
      default: e.pc = (a + imm_i) & 32'hFFFFFFFE;
    endcase
    e.rd2   = b2;
    e.valid = valid_i;
    e.wb    = wb_sel_i;
    e.rwe   = reg_write_enable_i & valid_i;
    e.mwe   = mem_write_enable_i & valid_i;
    e.wrs   = write_reg_sel_i;
    return e;
  endfunction

  task automatic popCompare();
    exp_t e;
    checkOutput("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkOutput({e.tag, ".res"},   64'(result_o),           64'(e.result));
    checkOutput({e.tag, ".pc"},    64'(pc_o),               64'(e.pc));
    checkOutput({e.tag, ".rd2"},   64'(read_data2_o),       64'(e.rd2));
    checkOutput({e.tag, ".valid"}, 64'(valid_o),            64'(e.valid));
    checkOutput({e.tag, ".wb"},    64'(wb_sel_o),           64'(e.wb));
    checkOutput({e.tag, ".rwe"},   64'(reg_write_enable_o), 64'(e.rwe));
    checkOutput({e.tag, ".mwe"},   64'(mem_write_enable_o), 64'(e.mwe));
    checkOutput({e.tag, ".wrs"},   64'(write_reg_sel_o),    64'(e.wrs));
    last_exp = e;
  endtask

  // One single-cycle transaction with the inputs already driven; a non-mul
  // transaction must never raise busy_o.
  task automatic applyStimulus(input string tag, input logic use_ref, input logic [31:0] ref_result);
    exp_t e;
    #1;
    checkOutput({tag, ".edest"},  64'(e_dest_reg_o),    64'(write_reg_sel_i));
    checkOutput({tag, ".edesten"}, 64'(e_dest_reg_en_o), 64'(reg_write_enable_i & valid_i));
    checkOutput({tag, ".busy"},   64'(busy_o),          64'd0);
    checkOutput({tag, ".evalid"}, 64'(e_valid_o),       64'd1);
    if (flush_i) begin
      e = modelLoad(tag);
      e.valid = 1'b0;
      e.rwe   = 1'b0;
      e.mwe   = 1'b0;
      e.pc    = pc_i;
    end else if (stall_i) begin
      e = last_exp;
      e.tag = tag;
    end else begin
      e = modelLoad(tag);
    end
    if (use_ref) e.result = ref_result;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    popCompare();
  endtask

  task automatic setDefaults();
    flush_i = 0; stall_i = 0; valid_i = 1;
    read_data1_i = 0; read_data2_i = 0; imm_i = 0; pc_i = 32'h40;
    fwd_data_i = 0; fwd_sel1_i = 0; fwd_sel2_i = 0;
    alu_op_i = 0; imm_sel_i = 0; mul_i = 0; mul_high_i = 0;
    branch_type_i = 0; wb_sel_i = 0; reg_write_enable_i = 1;
    mem_write_enable_i = 0; write_reg_sel_i = 5'd3;
  endtask

  task automatic clearLastExp();
    last_exp.tag = "rst"; last_exp.result = 0; last_exp.pc = 0; last_exp.rd2 = 0;
    last_exp.valid = 0; last_exp.wb = 0; last_exp.rwe = 0; last_exp.mwe = 0; last_exp.wrs = 0;
  endtask

`ifdef EXE_MUL_EN
  // Drives one multiply and waits (bounded) for its EX/MEM capture. stall_i is
  // raised for cycles [stall_start, stall_end) counted from presentation.
  task automatic mulTransaction(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic high, input int stall_start, input int stall_end);
    exp_t        e;
    logic [63:0] prod;
    int          busy_cycles, cap, exp_cap;
    logic        got;
    valid_i = 1; mul_i = 1; mul_high_i = high; alu_op_i = 0; imm_sel_i = 0;
    fwd_sel1_i = 0; fwd_sel2_i = 0; read_data1_i = a; read_data2_i = b;
    branch_type_i = 0; pc_i = 32'h300; write_reg_sel_i = 5'd7; reg_write_enable_i = 1;
    e = modelLoad(tag);
    prod = {32'd0, a} * {32'd0, b};
    e.result = high ? prod[63:32] : prod[31:0];
    sb.push_back(e);
    exp_cap = (stall_start <= XLEN + 1 && stall_end > XLEN + 1) ? stall_end : XLEN + 1;
    busy_cycles = 0; cap = -1; got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      stall_i = (c >= stall_start && c < stall_end);
      #1;
      if (busy_o) busy_cycles++;
      @(posedge clk_i);
      #1;
      if (valid_o) begin
        got = 1;
        cap = c;
      end
    end
    stall_i = 0;
    if (!got) begin
      checkOutput({tag, ".timeout"}, 64'd0, 64'd1);
      sb.delete();
    end else begin
      popCompare();
    end
    checkOutput({tag, ".busycyc"}, 64'(busy_cycles), 64'(exp_cap));
    checkOutput({tag, ".capcyc"},  64'(cap),         64'(exp_cap));
  endtask
`endif

  initial begin
    int bad;
    setDefaults();
    clearLastExp();
    valid_i = 0;
    rst_n_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst.res",   64'(result_o),           64'd0);
    checkOutput("rst.pc",    64'(pc_o),               64'd0);
    checkOutput("rst.valid", 64'(valid_o),            64'd0);
    checkOutput("rst.rwe",   64'(reg_write_enable_o), 64'd0);
    checkOutput("rst.busy",  64'(busy_o),             64'd0);
    rst_n_i = 1;

    // Wrapping ADD and forwarding selection.
    setDefaults();
    read_data1_i = 32'hFFFFFFFF; read_data2_i = 32'd2;
    applyStimulus("add_wrap", 1, 32'h00000001);
    setDefaults();
    fwd_data_i = {32'h00001234, 32'hAAAA0000}; fwd_sel1_i = 2; imm_i = 4; imm_sel_i = 1;
    applyStimulus("fwd_src1", 1, 32'h00001238);
    fwd_sel1_i = 3; read_data1_i = 32'h10;
    applyStimulus("fwd_sel3_rf", 1, 32'h00000014);
    fwd_sel1_i = 1;
    applyStimulus("fwd_src0", 1, 32'hAAAA0004);
    imm_sel_i = 0; fwd_sel2_i = 1; read_data2_i = 32'h5; mem_write_enable_i = 1;
    applyStimulus("fwd_b2_store", 1, 32'h55540000);

    // Directed ALU vectors.
    foreach (vecs[i]) begin
      setDefaults();
      alu_op_i = vecs[i].op; read_data1_i = vecs[i].a; read_data2_i = vecs[i].b;
      applyStimulus($sformatf("alu%0d_op%0d", i, vecs[i].op), 1, vecs[i].r);
    end

    // Branch resolution.
    setDefaults();
    branch_type_i = 1; alu_op_i = 11; read_data1_i = 5; read_data2_i = 6;
    pc_i = 32'h100; imm_i = 32'h20;
    applyStimulus("br_ne_taken", 0, 0);
    checkOutput("br_ne_taken.pcconst", 64'(pc_o), 64'h120);
    read_data2_i = 5;
    applyStimulus("br_ne_nt", 0, 0);
    checkOutput("br_ne_nt.pcconst", 64'(pc_o), 64'h104);
    branch_type_i = 2;
    applyStimulus("jal", 0, 0);
    checkOutput("jal.pcconst", 64'(pc_o), 64'h120);
    branch_type_i = 3; read_data1_i = 32'h201; imm_i = 0;
    applyStimulus("jalr", 0, 0);
    checkOutput("jalr.pcconst", 64'(pc_o), 64'h200);

    // Bubble, stall hold, flush beating stall.
    setDefaults();
    valid_i = 0; mem_write_enable_i = 1; read_data1_i = 9;
    applyStimulus("bubble", 0, 0);
    setDefaults();
    read_data1_i = 32'h77; wb_sel_i = 1;
    applyStimulus("pre_stall", 0, 0);
    read_data1_i = 32'h99; stall_i = 1; pc_i = 32'h500;
    applyStimulus("stall_hold", 0, 0);
    checkOutput("stall_hold.resconst", 64'(result_o), 64'h77);
    flush_i = 1;
    applyStimulus("flush_over_stall", 0, 0);
    checkOutput("flush_over_stall.pcconst", 64'(pc_o), 64'h500);

`ifndef EXE_MUL_EN
    // Without the multiplier a mul instruction is a plain ALU op.
    setDefaults();
    mul_i = 1; mul_high_i = 1; read_data1_i = 32'd6; read_data2_i = 32'd7;
    applyStimulus("mul_ignored", 1, 32'd13);
`endif

    // Random traffic through the scoreboard.
    for (int n = 0; n < 60; n++) begin
      setDefaults();
      valid_i = ($urandom_range(0, 5) != 0);
      flush_i = ($urandom_range(0, 9) == 0);
      stall_i = ($urandom_range(0, 6) == 0);
      read_data1_i = $urandom; read_data2_i = $urandom; imm_i = $urandom;
      pc_i = $urandom; fwd_data_i = {$urandom, $urandom};
      fwd_sel1_i = FSEL_W'($urandom_range(0, 3)); fwd_sel2_i = FSEL_W'($urandom_range(0, 3));
      alu_op_i = 4'($urandom_range(0, 15)); imm_sel_i = 1'($urandom_range(0, 1));
      branch_type_i = 2'($urandom_range(0, 3)); wb_sel_i = 1'($urandom_range(0, 1));
      reg_write_enable_i = 1'($urandom_range(0, 1)); mem_write_enable_i = 1'($urandom_range(0, 1));
      write_reg_sel_i = 5'($urandom_range(0, 31));
`ifndef EXE_MUL_EN
      mul_i = 1'($urandom_range(0, 1)); mul_high_i = 1'($urandom_range(0, 1));
`endif
      applyStimulus($sformatf("rnd%0d", n), 0, 0);
    end

`ifdef EXE_MUL_EN
    setDefaults();
    mulTransaction("mul_hi_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1000, 1000);
    checkOutput("mul_hi_ff.const", 64'(result_o), 64'hFFFFFFFE);
    mulTransaction("mul_lo_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1000, 1000);
    checkOutput("mul_lo_ff.const", 64'(result_o), 64'h00000001);
    mulTransaction("mul_b2b_hi", 32'h12345678, 32'h9ABCDEF0, 1, 1000, 1000);
    mulTransaction("mul_stall", 32'h0000FFFF, 32'h00010001, 0, 20, 40);
    setDefaults();
    valid_i = 0;
    applyStimulus("after_mul_nodup", 0, 0);

    // Flush in the middle of a multiply.
    setDefaults();
    valid_i = 1; mul_i = 1; read_data1_i = 32'd3; read_data2_i = 32'd4;
    pc_i = 32'h600; write_reg_sel_i = 5'd9;
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end
    flush_i = 1;
    begin
      exp_t e;
      e = modelLoad("mul_flush");
      e.valid = 0; e.rwe = 0; e.mwe = 0; e.pc = pc_i;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    flush_i = 0; valid_i = 0; mul_i = 0; read_data1_i = 0; read_data2_i = 0;
    #1;
    checkOutput("mul_flush.busy", 64'(busy_o), 64'd0);
    popCompare();
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i);
      #1;
      if (busy_o || result_o != 0) bad++;
    end
    checkOutput("mul_flush.quiet", 64'(bad), 64'd0);

    // Reset in the middle of a multiply.
    setDefaults();
    mulTransaction("mul_pre_rst", 32'd5, 32'd6, 0, 1000, 1000);
    valid_i = 1; mul_i = 1; read_data1_i = 32'd8; read_data2_i = 32'd8;
    repeat (5) begin
      @(posedge clk_i);
      #1;
    end
    rst_n_i = 0; valid_i = 0; mul_i = 0;
    #1;
    checkOutput("mul_rst.busy",  64'(busy_o),   64'd0);
    checkOutput("mul_rst.valid", 64'(valid_o),  64'd0);
    checkOutput("mul_rst.res",   64'(result_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1;
    clearLastExp();
    setDefaults();
    read_data1_i = 32'd40; read_data2_i = 32'd2;
    applyStimulus("post_rst_add", 1, 32'd42);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
